// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product operand read path.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH      = 2;
    localparam int PAIR_DATA_WIDTH = 8;

    typedef struct packed {
        logic [PAIR_DATA_WIDTH-1:0] a;
        logic [PAIR_DATA_WIDTH-1:0] b;
        logic                       last;
    } pair_t;

endpackage

// File: rtl/pair_skid_fifo.sv
// Two-entry synchronous FIFO holding operand pairs between memory read-out and the MAC stream.
module pair_skid_fifo
    import dp_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    assign head  = mem[rd_ptr];
    assign valid = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_pair_reader.sv
// Read sequencer: walks operand memories A and B in lockstep and streams element pairs to the MAC.
module vec_pair_reader
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_last
);

    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  issued_cnt;
    logic [LEN_WIDTH-1:0]  accepted_cnt;
    logic                  done_r;
    logic                  vld_p1;
    logic                  last_p1;

    logic [PW-1:0]         push_data;
    logic [PW-1:0]         head;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic [2:0]            occupancy;

    // Credit: buffered plus in-flight pairs, minus the one leaving this cycle, must stay below depth.
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1};
    assign pop       = fifo_valid && out_ready;
    assign rd_en     = (state == RUN) && (issued_cnt < len_r) &&
                       (occupancy < (3'(FIFO_DEPTH) + {2'b00, pop}));
    assign rd_addr   = base_r + issued_cnt[ADDR_WIDTH-1:0];

    assign push_data = {rd_data_a, rd_data_b, last_p1};
    assign out_valid = fifo_valid;
    assign out_a     = head[PW-1 -: DATA_WIDTH];
    assign out_b     = head[DATA_WIDTH:1];
    assign out_last  = head[0];
    assign busy      = (state != IDLE);
    assign done      = done_r;

    pair_skid_fifo #(
        .WIDTH(PW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_r       <= '0;
            len_r        <= '0;
            issued_cnt   <= '0;
            accepted_cnt <= '0;
            done_r       <= 1'b0;
            vld_p1       <= 1'b0;
            last_p1      <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            // Memory read stage: tag the element that lands next cycle.
            vld_p1  <= rd_en;
            last_p1 <= rd_en && (issued_cnt == len_r - LEN_ONE);
            if (rd_en) issued_cnt <= issued_cnt + LEN_ONE;
            if (pop) accepted_cnt <= accepted_cnt + LEN_ONE;

            case (state)
                IDLE: begin
                    if (start && !done_r) begin
                        base_r       <= base_addr;
                        len_r        <= length;
                        issued_cnt   <= '0;
                        accepted_cnt <= '0;
                        if (length == '0) done_r <= 1'b1;
                        else              state  <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en && (issued_cnt == len_r - LEN_ONE)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (accepted_cnt == len_r - LEN_ONE)) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_pair_reader.sv
// Directed bench for vec_pair_reader with registered-read memory models for A and B.
module tb_vec_pair_reader;
    import dp_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy, done, rd_en, out_valid, out_ready, out_last;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a, rd_data_b, out_a, out_b;

    vec_pair_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    initial begin
        rd_data_a = '0;
        rd_data_b = '0;
    end
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    pair_t         hs_q[$];
    int            hs_cyc_q[$];
    logic [AW-1:0] addr_q[$];
    int rd_issued, popped, max_out, done_cnt, done_cyc, first_valid_cyc;
    int stall_bad, busy_done_bad;
    bit busy_seen, stalled_prev;
    pair_t held;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                addr_q.push_back(rd_addr);
                rd_issued++;
            end
            if (out_valid && out_ready) begin
                hs_q.push_back({out_a, out_b, out_last});
                hs_cyc_q.push_back(cyc);
                popped++;
            end
            if (rd_issued - popped > max_out) max_out = rd_issued - popped;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done && busy) busy_done_bad++;
            if (busy) busy_seen = 1'b1;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && stalled_prev && (pair_t'({out_a, out_b, out_last}) !== held))
                stall_bad++;
            stalled_prev = out_valid && !out_ready;
            held = {out_a, out_b, out_last};
        end
    end

    function automatic pair_t exp_pair(int b, int i, int len);
        logic [AW-1:0] ad;
        ad = AW'(b + i);
        return {8'h11 + {4'h0, ad}, 8'h80 + {4'h0, ad}, (i == len - 1)};
    endfunction

    task automatic clear_mon();
        hs_q.delete();
        hs_cyc_q.delete();
        addr_q.delete();
        rd_issued = 0; popped = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; stall_bad = 0; busy_done_bad = 0;
        busy_seen = 1'b0; stalled_prev = 1'b0;
    endtask

    task automatic do_start(input int b, input int l, output int t);
        @(posedge clk); #1;
        base_addr = AW'(b);
        length    = LW'(l);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = cyc;
    endtask

    // mode 0: ready high; mode 1: ready low for cycles 4..9 after start; mode 2: random ready
    task automatic run_until_done(input int mode, input int t, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            case (mode)
                1:       out_ready = !((cyc - t) >= 4 && (cyc - t) <= 9);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, rd_en, out_valid, out_last, rd_addr, out_a, out_b} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, rd_en, out_valid, out_last, rd_addr, out_a, out_b});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, rd_en, out_valid} !== 4'b0)
            $display("FAIL idle_after_reset: got %b want 0000", {busy, done, rd_en, out_valid});
        else n_pass++;
    endtask

    task automatic test_basic();
        int t; bit ok;
        clear_mon();
        out_ready = 1'b1;
        do_start(0, 4, t);
        run_until_done(0, t, 100, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL basic_timeout: got %0d want 1", ok); else n_pass++;
        n_total++;
        if (hs_q.size() != 4) $display("FAIL basic_count: got %0d want 4", hs_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
            n_total++;
            if (hs_q[i] !== exp_pair(0, i, 4))
                $display("FAIL basic_pair%0d: got %h want %h", i, hs_q[i], exp_pair(0, i, 4));
            else n_pass++;
            n_total++;
            if (hs_cyc_q[i] != t + 2 + i)
                $display("FAIL basic_cycle%0d: got %0d want %0d", i, hs_cyc_q[i], t + 2 + i);
            else n_pass++;
        end
        n_total++;
        if (done_cyc != t + 6) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, t + 6);
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || busy_done_bad != 0)
            $display("FAIL basic_done_pulse: got cnt=%0d overlap=%0d want cnt=1 overlap=0",
                     done_cnt, busy_done_bad);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int t; bit ok;
        clear_mon();
        do_start(0, 8, t);
        run_until_done(1, t, 200, ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL bp_timeout: got %0d want 1", ok); else n_pass++;
        n_total++;
        if (hs_q.size() != 8 || addr_q.size() != 8)
            $display("FAIL bp_count: got pairs=%0d reads=%0d want 8/8", hs_q.size(), addr_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
            n_total++;
            if (hs_q[i] !== exp_pair(0, i, 8))
                $display("FAIL bp_pair%0d: got %h want %h", i, hs_q[i], exp_pair(0, i, 8));
            else n_pass++;
        end
        n_total++;
        if (max_out != 2) $display("FAIL bp_outstanding: got %0d want 2", max_out); else n_pass++;
        n_total++;
        if (stall_bad != 0) $display("FAIL bp_stable: got %0d changes want 0", stall_bad);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int t; bit ok;
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        clear_mon();
        do_start(14, 4, t);
        run_until_done(0, t, 100, ok);
        n_total++;
        if (ok !== 1'b1 || addr_q.size() != 4 || hs_q.size() != 4)
            $display("FAIL wrap_count: got ok=%0d reads=%0d pairs=%0d want 1/4/4",
                     ok, addr_q.size(), hs_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < addr_q.size() && i < hs_q.size(); i++) begin
            n_total++;
            if (addr_q[i] !== exp_addr[i])
                $display("FAIL wrap_addr%0d: got %0d want %0d", i, addr_q[i], exp_addr[i]);
            else n_pass++;
            n_total++;
            if (hs_q[i] !== exp_pair(14, i, 4))
                $display("FAIL wrap_pair%0d: got %h want %h", i, hs_q[i], exp_pair(14, i, 4));
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        int t;
        clear_mon();
        do_start(3, 0, t);
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (done_cnt != 1 || done_cyc != t)
            $display("FAIL zero_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, t);
        else n_pass++;
        n_total++;
        if (addr_q.size() != 0 || first_valid_cyc != -1 || busy_seen)
            $display("FAIL zero_quiet: got reads=%0d valid_cyc=%0d busy=%0d want 0/-1/0",
                     addr_q.size(), first_valid_cyc, busy_seen);
        else n_pass++;
    endtask

    task automatic test_start_busy_reset();
        int t; bit ok; bit hit;
        clear_mon();
        do_start(0, 6, t);
        @(posedge clk); #1;
        base_addr = 4'd5; length = 5'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(0, t, 100, ok);
        n_total++;
        if (ok !== 1'b1 || done_cnt != 1 || addr_q.size() != 6 || hs_q.size() != 6)
            $display("FAIL busy_start_count: got ok=%0d done=%0d reads=%0d pairs=%0d want 1/1/6/6",
                     ok, done_cnt, addr_q.size(), hs_q.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < hs_q.size(); i++) begin
            n_total++;
            if (hs_q[i] !== exp_pair(0, i, 6))
                $display("FAIL busy_start_pair%0d: got %h want %h", i, hs_q[i], exp_pair(0, i, 6));
            else n_pass++;
        end

        clear_mon();
        do_start(0, 8, t);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (popped == 2) begin
                hit = 1'b1;
                break;
            end
        end
        n_total++;
        if (hit !== 1'b1) $display("FAIL reset_mid_reach: got %0d want 1", hit); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, rd_en, out_valid, out_last, rd_addr, out_a, out_b} !== '0)
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {busy, done, rd_en, out_valid, out_last, rd_addr, out_a, out_b});
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (done_cnt != 0 || out_valid !== 1'b0)
            $display("FAIL reset_mid_nodone: got done=%0d valid=%0d want 0/0", done_cnt, out_valid);
        else n_pass++;

        clear_mon();
        do_start(3, 2, t);
        run_until_done(0, t, 100, ok);
        n_total++;
        if (ok !== 1'b1 || hs_q.size() != 2 || done_cnt != 1)
            $display("FAIL post_reset_count: got ok=%0d pairs=%0d done=%0d want 1/2/1",
                     ok, hs_q.size(), done_cnt);
        else n_pass++;
        for (int i = 0; i < 2 && i < hs_q.size(); i++) begin
            n_total++;
            if (hs_q[i] !== exp_pair(3, i, 2) || hs_cyc_q[i] != t + 2 + i)
                $display("FAIL post_reset_pair%0d: got %h@%0d want %h@%0d",
                         i, hs_q[i], hs_cyc_q[i], exp_pair(3, i, 2), t + 2 + i);
            else n_pass++;
        end
    endtask

    task automatic test_full_random();
        int t; bit ok;
        clear_mon();
        do_start(0, 16, t);
        run_until_done(2, t, 500, ok);
        n_total++;
        if (ok !== 1'b1 || hs_q.size() != 16 || done_cnt != 1)
            $display("FAIL full_count: got ok=%0d pairs=%0d done=%0d want 1/16/1",
                     ok, hs_q.size(), done_cnt);
        else n_pass++;
        for (int i = 0; i < 16 && i < hs_q.size(); i++) begin
            n_total++;
            if (hs_q[i] !== exp_pair(0, i, 16))
                $display("FAIL full_pair%0d: got %h want %h", i, hs_q[i], exp_pair(0, i, 16));
            else n_pass++;
        end
        n_total++;
        if (stall_bad != 0 || max_out > 2)
            $display("FAIL full_flow: got changes=%0d outstanding=%0d want 0/<=2", stall_bad, max_out);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h11 + 8'(i);
            mem_b[i] = 8'h80 + 8'(i);
        end
        start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_start_busy_reset();
        test_full_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
